// File: rtl/mcycle_unit_if.sv
// Request/response bundle between the decoder datapath and the multi-cycle multiply/divide unit.
interface mcycle_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative shift-add multiplier / restoring divider, one step per clock.
// Optional MCYCLE_EARLY_EXIT_EN: multiplies finish once the remaining multiplier is zero.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    mcycle_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      count;
    logic               last_step;

    logic               is_div, neg_res, neg_rem, div_zero;
    logic [WIDTH-1:0]   op1_q;
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt, prod;
    logic [WIDTH-1:0]   mplier, dvsr, quo, rem, quo_nxt, rem_nxt;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               rem_ge;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH-1:0]   res1_nxt, res2_nxt;

    // Signed ops work on magnitudes; signs are reapplied when the result is written.
    always_comb begin
        a_neg = bus.MCycleOp[0] & bus.Operand1[WIDTH-1];
        b_neg = bus.MCycleOp[0] & bus.Operand2[WIDTH-1];
        mag1  = a_neg ? -bus.Operand1 : bus.Operand1;
        mag2  = b_neg ? -bus.Operand2 : bus.Operand2;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc_nxt  = acc + (mplier[0] ? mcand : '0);
        rem_sh   = {rem, quo[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dvsr};
        rem_ge   = ~rem_diff[WIDTH];
        rem_nxt  = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt  = {quo[WIDTH-2:0], rem_ge};
        prod     = neg_res ? -acc_nxt : acc_nxt;
        res1_nxt = prod[WIDTH-1:0];
        res2_nxt = prod[2*WIDTH-1:WIDTH];
        if (is_div) begin
            if (div_zero) begin
                res1_nxt = '1;
                res2_nxt = op1_q;
            end else begin
                res1_nxt = neg_res ? -quo_nxt : quo_nxt;
                res2_nxt = neg_rem ? -rem_nxt : rem_nxt;
            end
        end
    end

`ifdef MCYCLE_EARLY_EXIT_EN
    assign last_step = (count == CW'(WIDTH - 1)) || (!is_div && mplier[WIDTH-1:1] == '0);
`else
    assign last_step = (count == CW'(WIDTH - 1));
`endif

    always_comb begin
        state_nxt = state;
        bus.Busy  = 1'b0;
        bus.Done  = 1'b0;
        case (state)
            IDLE: begin
                bus.Busy = bus.Start;
                if (bus.Start) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                bus.Busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                // Start may still be high here: it belongs to the retiring instruction.
                bus.Done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            count       <= '0;
            bus.Result1 <= '0;
            bus.Result2 <= '0;
        end else begin
            state <= state_nxt;
            if (state == COMPUTE) count <= count + 1'b1;
            else                  count <= '0;
            if (state == COMPUTE && last_step) begin
                bus.Result1 <= res1_nxt;
                bus.Result2 <= res2_nxt;
            end
        end
    end

    // NOTE: datapath registers are always loaded before use, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (state == IDLE && bus.Start) begin
            is_div   <= bus.MCycleOp[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (bus.Operand2 == '0);
            op1_q    <= bus.Operand1;
            mcand    <= {{WIDTH{1'b0}}, mag1};
            mplier   <= mag2;
            acc      <= '0;
            dvsr     <= mag2;
            quo      <= mag1;
            rem      <= '0;
        end else if (state == COMPUTE) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nxt;
            quo    <= quo_nxt;
            rem    <= rem_nxt;
        end
    end
endmodule
